// File: rtl/agu_pkg.sv
// rtl/agu_pkg.sv - shared constants and FSM state type for the AGU index generator
package agu_pkg;

  localparam int IDX_W_DEF = 11;
  localparam int ADR_W_DEF = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } agu_state_e;

endpackage

// File: rtl/agu_loop_ctr.sv
// rtl/agu_loop_ctr.sv - single-dimension loop counter with start/end/stride and wrap flag
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_load            latch start/end/stride and set value to start
//   step                advance: value += stride, or reload start when wrap
//   start_in/end_in/stride_in  loop configuration (inclusive end, stride 0 -> 1)
//   value               current loop value
//   wrap                value + stride would exceed end (computed one bit wider)
module agu_loop_ctr
  import agu_pkg::*;
#(
  parameter int W = IDX_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_load,
  input  logic         step,
  input  logic [W-1:0] start_in,
  input  logic [W-1:0] end_in,
  input  logic [W-1:0] stride_in,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] start_q, end_q, stride_q;
  logic [W-1:0] val_q, val_d;
  logic [W:0]   sum;

  // Extra bit keeps an end value near the top of the range from wrapping
  // back to a small number and looking "in range".
  assign sum  = {1'b0, val_q} + {1'b0, stride_q};
  assign wrap = (sum > {1'b0, end_q});

  always_comb begin
    val_d = val_q;
    if (cfg_load) begin
      val_d = start_in;
    end else if (step) begin
      val_d = wrap ? start_q : sum[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q  <= '0;
      end_q    <= '0;
      stride_q <= '0;
      val_q    <= '0;
    end else begin
      if (cfg_load) begin
        start_q  <= start_in;
        end_q    <= end_in;
        stride_q <= (stride_in == '0) ? ONE : stride_in;
      end
      val_q <= val_d;
    end
  end

  assign value = val_q;

endmodule

// File: rtl/agu_index_gen.sv
// rtl/agu_index_gen.sv - two-level (i outer, j inner) index sweep generator feeding the AGU
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cfg_valid / cfg_ready           configuration handshake (ready only in IDLE)
//   start_0, end_0, stride_0        outer loop i, inclusive bounds
//   start_1, end_1, stride_1        inner loop j, inclusive bounds
//   base_adr_in                     base address latched for the sweep
//   abort                           cancel current sweep (ignored in IDLE)
//   idx_valid / idx_ready           beat handshake toward the AGU
//   index_0, index_1, base_adr      current i, j and latched base
//   last                            current beat is the final one
//   done                            one-cycle pulse after the final beat
//   cfg_err                         one-cycle pulse after an empty-range config
module agu_index_gen
  import agu_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int ADR_W = ADR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IDX_W-1:0] start_0,
  input  logic [IDX_W-1:0] end_0,
  input  logic [IDX_W-1:0] stride_0,
  input  logic [IDX_W-1:0] start_1,
  input  logic [IDX_W-1:0] end_1,
  input  logic [IDX_W-1:0] stride_1,
  input  logic [ADR_W-1:0] base_adr_in,
  input  logic             abort,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [IDX_W-1:0] index_0,
  output logic [IDX_W-1:0] index_1,
  output logic [ADR_W-1:0] base_adr,
  output logic             last,
  output logic             done,
  output logic             cfg_err
);

  agu_state_e       state_q, state_d;
  logic             cfg_err_q, cfg_err_d;
  logic [ADR_W-1:0] base_q, base_d;

  logic hs, range_ok, cfg_load, beat, step_j, step_i;
  logic wrap_0, wrap_1;
  logic in_run;

  assign in_run   = (state_q == ST_RUN);
  assign cfg_ready = (state_q == ST_IDLE);
  assign hs       = cfg_valid && cfg_ready;
  assign range_ok = (start_0 <= end_0) && (start_1 <= end_1);
  // Only a non-empty config is latched, so the index/base outputs keep
  // showing the previous sweep after a rejected one.
  assign cfg_load = hs && range_ok;

  assign idx_valid = in_run;
  assign last      = in_run && wrap_0 && wrap_1;
  assign beat      = in_run && idx_ready;

  // Abort wins over a simultaneous beat; the final beat does not advance
  // the counters so the indices hold their last values afterwards.
  assign step_j = beat && !abort && !last;
  assign step_i = step_j && wrap_1;

  agu_loop_ctr #(.W(IDX_W)) u_ctr_inner (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_load  (cfg_load),
    .step      (step_j),
    .start_in  (start_1),
    .end_in    (end_1),
    .stride_in (stride_1),
    .value     (index_1),
    .wrap      (wrap_1)
  );

  agu_loop_ctr #(.W(IDX_W)) u_ctr_outer (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_load  (cfg_load),
    .step      (step_i),
    .start_in  (start_0),
    .end_in    (end_0),
    .stride_in (stride_0),
    .value     (index_0),
    .wrap      (wrap_0)
  );

  always_comb begin
    state_d   = state_q;
    cfg_err_d = 1'b0;
    base_d    = base_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hs) begin
          if (range_ok) begin
            state_d = ST_RUN;
            base_d  = base_adr_in;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (beat && last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cfg_err_q <= 1'b0;
      base_q    <= '0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= cfg_err_d;
      base_q    <= base_d;
    end
  end

  assign done     = (state_q == ST_DONE);
  assign cfg_err  = cfg_err_q;
  assign base_adr = base_q;

endmodule

// File: tb/tb_agu_index_gen.sv
// tb/tb_agu_index_gen.sv - self-checking bench for agu_index_gen against a nested-loop model
module tb_agu_index_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [10:0] start_0, end_0, stride_0, start_1, end_1, stride_1;
  logic [19:0] base_adr_in;
  logic        abort;
  logic        idx_valid;
  logic        idx_ready;
  logic [10:0] index_0, index_1;
  logic [19:0] base_adr;
  logic        last, done, cfg_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  int exp_i[$], exp_j[$];
  int q_i[$], q_j[$], q_last[$], q_b[$];
  int stall_bad;
  bit done_ok;
  bit timed_out;

  always #5 clk = ~clk;

  agu_index_gen dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .start_0(start_0), .end_0(end_0), .stride_0(stride_0),
    .start_1(start_1), .end_1(end_1), .stride_1(stride_1),
    .base_adr_in(base_adr_in), .abort(abort),
    .idx_valid(idx_valid), .idx_ready(idx_ready),
    .index_0(index_0), .index_1(index_1), .base_adr(base_adr),
    .last(last), .done(done), .cfg_err(cfg_err)
  );

  // Reference: plain nested loops over integers, stride 0 treated as 1.
  task automatic build_exp(input int s0, input int e0, input int st0,
                           input int s1, input int e1, input int st1);
    int a0, a1;
    exp_i.delete();
    exp_j.delete();
    a0 = (st0 == 0) ? 1 : st0;
    a1 = (st1 == 0) ? 1 : st1;
    for (int i = s0; i <= e0; i += a0)
      for (int j = s1; j <= e1; j += a1) begin
        exp_i.push_back(i);
        exp_j.push_back(j);
      end
  endtask

  // Drives one config handshake; called just after a rising edge in IDLE.
  task automatic apply_cfg(input int s0, input int e0, input int st0,
                           input int s1, input int e1, input int st1, input int b);
    start_0 = 11'(s0); end_0 = 11'(e0); stride_0 = 11'(st0);
    start_1 = 11'(s1); end_1 = 11'(e1); stride_1 = 11'(st1);
    base_adr_in = 20'(b);
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  // Stimulus/capture only: records accepted beats, stall stability and done timing.
  task automatic collect(input int stall_pct, input int max_cycles);
    int pi, pj, pl, pb;
    bit stalled, took_last;
    q_i.delete(); q_j.delete(); q_last.delete(); q_b.delete();
    stall_bad = 0; done_ok = 0; timed_out = 1; stalled = 0; took_last = 0;
    pi = 0; pj = 0; pl = 0; pb = 0;
    for (int c = 0; c < max_cycles; c++) begin
      if (took_last) begin
        done_ok = (done === 1'b1) && (idx_valid === 1'b0);
        timed_out = 0;
        break;
      end
      if (stalled) begin
        if (idx_valid !== 1'b1 || int'(index_0) != pi || int'(index_1) != pj ||
            int'(last) != pl || int'(base_adr) != pb)
          stall_bad++;
      end
      stalled = 0;
      if (idx_valid === 1'b1) begin
        idx_ready = ($urandom_range(0, 99) >= stall_pct);
        pi = int'(index_0); pj = int'(index_1); pl = int'(last); pb = int'(base_adr);
        if (idx_ready) begin
          q_i.push_back(pi); q_j.push_back(pj); q_last.push_back(pl); q_b.push_back(pb);
          took_last = (pl == 1);
        end else begin
          stalled = 1;
        end
      end else begin
        idx_ready = 1'b0;
      end
      @(posedge clk); #1;
    end
    idx_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({cfg_ready, idx_valid, last, done, cfg_err} !== 5'b10000)
      $display("FAIL reset_ctrl got=%b want=10000", {cfg_ready, idx_valid, last, done, cfg_err});
    else pass_cnt++;
    total_cnt++;
    if (index_0 !== 11'd0 || index_1 !== 11'd0 || base_adr !== 20'd0)
      $display("FAIL reset_data got=%0d,%0d,%0d want=0,0,0", index_0, index_1, base_adr);
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int bad;
    build_exp(0, 2, 1, 0, 1, 1);
    apply_cfg(0, 2, 1, 0, 1, 1, 20'h12345);
    total_cnt++;
    if (idx_valid !== 1'b1 || index_0 !== 11'd0 || index_1 !== 11'd0 || cfg_ready !== 1'b0)
      $display("FAIL basic_latency got v=%b i=%0d j=%0d rdy=%b want v=1 i=0 j=0 rdy=0",
               idx_valid, index_0, index_1, cfg_ready);
    else pass_cnt++;
    collect(0, 100);
    bad = 0;
    for (int k = 0; k < q_i.size() && k < exp_i.size(); k++)
      if (q_i[k] != exp_i[k] || q_j[k] != exp_j[k] || q_last[k] != int'(k == exp_i.size() - 1) ||
          q_b[k] != 32'h12345) bad++;
    total_cnt++;
    if (q_i.size() != exp_i.size() || bad != 0)
      $display("FAIL basic_beats got n=%0d bad=%0d want n=%0d bad=0", q_i.size(), bad, exp_i.size());
    else pass_cnt++;
    total_cnt++;
    if (!done_ok || timed_out) $display("FAIL basic_done got ok=%0d to=%0d want ok=1 to=0", done_ok, timed_out);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (done !== 1'b0 || cfg_ready !== 1'b1 || index_0 !== 11'd2 || index_1 !== 11'd1)
      $display("FAIL basic_after got done=%b rdy=%b i=%0d j=%0d want 0 1 2 1", done, cfg_ready, index_0, index_1);
    else pass_cnt++;
  endtask

  task automatic test_stride0;
    int bad;
    build_exp(4, 10, 3, 5, 5, 0);
    apply_cfg(4, 10, 3, 5, 5, 0, 7);
    collect(0, 100);
    bad = 0;
    for (int k = 0; k < q_i.size() && k < exp_i.size(); k++)
      if (q_i[k] != exp_i[k] || q_j[k] != exp_j[k] || q_last[k] != int'(k == exp_i.size() - 1)) bad++;
    total_cnt++;
    if (q_i.size() != 3 || exp_i.size() != 3 || bad != 0)
      $display("FAIL stride0_beats got n=%0d bad=%0d want n=3 bad=0", q_i.size(), bad);
    else pass_cnt++;
    total_cnt++;
    if (!done_ok) $display("FAIL stride0_done got %0d want 1", done_ok);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_top_end;
    int bad;
    build_exp(0, 1, 1, 2040, 2047, 4);
    apply_cfg(0, 1, 1, 2040, 2047, 4, 99);
    collect(20, 200);
    bad = 0;
    for (int k = 0; k < q_i.size() && k < exp_i.size(); k++)
      if (q_i[k] != exp_i[k] || q_j[k] != exp_j[k] || q_last[k] != int'(k == exp_i.size() - 1)) bad++;
    total_cnt++;
    if (q_i.size() != 4 || bad != 0 || !done_ok)
      $display("FAIL top_end got n=%0d bad=%0d done=%0d want n=4 bad=0 done=1", q_i.size(), bad, done_ok);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_stalls;
    int bad;
    for (int r = 0; r < 8; r++) begin
      int s0, e0, st0, s1, e1, st1, b;
      s0 = ($urandom_range(0, 3) == 0) ? 2047 - $urandom_range(0, 5) : $urandom_range(0, 2000);
      e0 = s0 + $urandom_range(0, 6); if (e0 > 2047) e0 = 2047;
      s1 = ($urandom_range(0, 3) == 0) ? 2047 - $urandom_range(0, 5) : $urandom_range(0, 2000);
      e1 = s1 + $urandom_range(0, 6); if (e1 > 2047) e1 = 2047;
      st0 = $urandom_range(0, 3);
      st1 = $urandom_range(0, 3);
      b = $urandom_range(0, 1048575);
      if (r == 0) begin s0 = 0; e0 = 2; st0 = 1; s1 = 0; e1 = 1; st1 = 1; end
      build_exp(s0, e0, st0, s1, e1, st1);
      apply_cfg(s0, e0, st0, s1, e1, st1, b);
      collect(40, 2000);
      bad = 0;
      for (int k = 0; k < q_i.size() && k < exp_i.size(); k++)
        if (q_i[k] != exp_i[k] || q_j[k] != exp_j[k] || q_last[k] != int'(k == exp_i.size() - 1) ||
            q_b[k] != b) bad++;
      total_cnt++;
      if (q_i.size() != exp_i.size() || bad != 0 || !done_ok)
        $display("FAIL stall_seq%0d got n=%0d bad=%0d done=%0d want n=%0d bad=0 done=1",
                 r, q_i.size(), bad, done_ok, exp_i.size());
      else pass_cnt++;
      total_cnt++;
      if (stall_bad != 0) $display("FAIL stall_hold%0d got changes=%0d want 0", r, stall_bad);
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cfg_err;
    int seen;
    apply_cfg(0, 4, 1, 3, 2, 1, 5);
    total_cnt++;
    if (cfg_err !== 1'b1 || idx_valid !== 1'b0 || cfg_ready !== 1'b1)
      $display("FAIL cfgerr_pulse got err=%b v=%b rdy=%b want 1 0 1", cfg_err, idx_valid, cfg_ready);
    else pass_cnt++;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (cfg_err !== 1'b0 || idx_valid !== 1'b0 || cfg_ready !== 1'b1) seen++;
    end
    total_cnt++;
    if (seen != 0) $display("FAIL cfgerr_after got bad_cycles=%0d want 0", seen);
    else pass_cnt++;
    apply_cfg(9, 8, 1, 0, 0, 1, 5);
    total_cnt++;
    if (cfg_err !== 1'b1 || idx_valid !== 1'b0)
      $display("FAIL cfgerr_outer got err=%b v=%b want 1 0", cfg_err, idx_valid);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_abort;
    int bad;
    apply_cfg(0, 3, 1, 0, 3, 1, 11);
    idx_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    idx_ready = 1'b0;
    total_cnt++;
    if (idx_valid !== 1'b0 || cfg_ready !== 1'b1 || done !== 1'b0 || index_0 !== 11'd0 || index_1 !== 11'd2)
      $display("FAIL abort_state got v=%b rdy=%b done=%b i=%0d j=%0d want 0 1 0 0 2",
               idx_valid, cfg_ready, done, index_0, index_1);
    else pass_cnt++;
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (idx_valid !== 1'b0 || done !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL abort_quiet got bad_cycles=%0d want 0", bad);
    else pass_cnt++;
    // abort while idle must not block a new config
    abort = 1'b1;
    build_exp(1, 1, 1, 0, 1, 1);
    apply_cfg(1, 1, 1, 0, 1, 1, 3);
    abort = 1'b0;
    total_cnt++;
    if (idx_valid !== 1'b1) $display("FAIL abort_idle got v=%b want 1", idx_valid);
    else pass_cnt++;
    collect(0, 50);
    total_cnt++;
    if (q_i.size() != exp_i.size() || !done_ok)
      $display("FAIL abort_idle_sweep got n=%0d done=%0d want n=%0d done=1", q_i.size(), done_ok, exp_i.size());
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int bad;
    apply_cfg(0, 5, 1, 0, 5, 1, 20'hABCDE);
    idx_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({cfg_ready, idx_valid, last, done, cfg_err} !== 5'b10000 ||
        index_0 !== 11'd0 || index_1 !== 11'd0 || base_adr !== 20'd0)
      $display("FAIL reset_mid got ctl=%b i=%0d j=%0d b=%0d want 10000 0 0 0",
               {cfg_ready, idx_valid, last, done, cfg_err}, index_0, index_1, base_adr);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (idx_valid !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) bad++;
    end
    idx_ready = 1'b0;
    total_cnt++;
    if (bad != 0) $display("FAIL reset_mid_quiet got bad_cycles=%0d want 0", bad);
    else pass_cnt++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    cfg_valid = 1'b0; abort = 1'b0; idx_ready = 1'b0;
    start_0 = '0; end_0 = '0; stride_0 = '0;
    start_1 = '0; end_1 = '0; stride_1 = '0;
    base_adr_in = '0;
    test_reset;
    test_basic;
    test_stride0;
    test_top_end;
    test_stalls;
    test_cfg_err;
    test_abort;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
